rs_bank: RTL
============

Name: rs_bank

Overview:
- Parametrised reservation-station bank for the Tomasulo LC-3b core; successor to the fixed 3-entry ALU station group.
- Holds NUM_RS in-flight ops and captures missing operands by snooping the CDB.
- Dispatches the oldest ready entry to one functional unit through a valid/ready handshake.
- Sits between issue_control (allocation) and an execution unit; one bank is instantiated per FU class.

Parameters:
- NUM_RS, 3, number of station entries (1..16).
- WORD_W, 16, operand/value width.
- TAG_W, 3, ROB tag width (lc3b_rob_addr).
- OP_W, 4, opcode width (lc3b_opcode).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all entries (mispredict).
- issue_valid  in  1  issue_control presents an op.
- issue_ready  out  1  at least one free entry; combinational from registered busy bits.
- issue_op  in  OP_W  opcode.
- issue_vj, issue_vk  in  WORD_W  operand values.
- issue_qj, issue_qk  in  TAG_W  producer ROB tags.
- issue_rdy_j, issue_rdy_k  in  1  operand value valid; when 0, the matching q field is used.
- issue_dest  in  TAG_W  ROB tag of the result.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_value  in  WORD_W  CDB value.
- ex_valid  out  1  dispatch candidate present.
- ex_ready  in  1  FU accepts.
- ex_op  out  OP_W  dispatched opcode.
- ex_a, ex_b  out  WORD_W  dispatched operands.
- ex_dest  out  TAG_W  dispatched ROB tag.
- busy_out  out  NUM_RS  per-entry busy.
- free_count  out  $clog2(NUM_RS+1)  number of non-busy entries.

Behaviour:
- Reset: all busy=0, rdy bits=0, age matrix cleared; busy_out=0, free_count=NUM_RS, issue_ready=1, ex_valid=0. Reset overrides issue, CDB and dispatch.
- Flush: same effect as reset on the next edge; a same-cycle issue is dropped and a same-cycle handshake is discarded (the FU ignores it under flush).
- Allocation: when issue_valid && issue_ready, write the lowest-index free entry and set busy=1 at the edge.
- Issue with no free entry: issue_ready=0; issue_valid is ignored and the caller holds.
- Issue-time CDB bypass: if issue_rdy_j=0 && cdb_valid && cdb_tag==issue_qj, store vj=cdb_value and rdy_j=1. Same rule for k.
- Snoop: every cycle, for each busy entry with rdy_j=0 and qj==cdb_tag && cdb_valid, capture the value and set rdy_j=1. Same for k. Several entries may capture in the same cycle.
- Age: an NUM_RS x NUM_RS age matrix. On allocation, the new entry is marked younger than all currently busy entries.
- Dispatch candidate: among busy entries with rdy_j && rdy_k, pick the oldest.
  - ex_valid and ex_* are combinational from registered state.
  - Wakeup to dispatch is a minimum of 1 cycle: a value captured at edge N makes the entry eligible in cycle N+1, never in the capture cycle.
- Handshake: on ex_valid && ex_ready, the candidate's busy clears at the edge.
  - While ex_ready=0, the candidate and ex_* stay stable unless an older entry becomes ready.
  - The FU samples only on the handshake, so candidate switching is legal.
- Freed entry reuse: a slot freed at edge N is visible to issue_ready in cycle N+1 (no same-cycle reuse).
- Simultaneous issue + dispatch + CDB in one cycle: all take effect independently at the same edge.
- Tags are compared only while the rdy bit is 0; tag value 0 has no special meaning.

Test Plan:
1. Reset, then issue ADD (vj=5, vk=7, both ready, dest=2) with ex_ready=1 -> ex_valid=1 the next cycle with ex_a=5, ex_b=7, ex_dest=2; busy_out returns to 0 after the handshake.
2. Issue an op with qj=4 pending; broadcast CDB tag=4 value=0x1234 two cycles later -> ex_valid rises the cycle after the broadcast, ex_a=0x1234.
3. Issue with qk=3 while the CDB broadcasts tag 3 value 9 in the same cycle -> bypass captures it; dispatch occurs next cycle with ex_b=9.
4. Fill all 3 entries with ex_ready=0 -> issue_ready=0, free_count=0, and a 4th issue is ignored. Raise ex_ready -> entries dispatch in issue order (dest 1, 2, 3).
5. Entries A (older) and B (younger) both waiting on tag 5; CDB tag 5 -> both wake in the same cycle; A dispatches first, then B.
6. Three busy entries; assert flush alongside issue_valid -> next cycle busy_out=0, ex_valid=0, free_count=3; the issued op is absent.

Source files
------------

// File: rtl/rs_bank.sv
// rs_bank: parametrised reservation-station bank for one functional-unit class.
// Holds NUM_RS in-flight ops. Missing operands are captured by snooping the CDB,
// both while resident and at issue time. The oldest entry whose operands are both
// ready is offered to the FU through a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              squash every entry on the next edge
//   issue_*            allocation request from issue_control (valid/ready)
//   cdb_*              common data bus broadcast (valid, tag, value)
//   ex_*               dispatch to the functional unit (valid/ready, op, a, b, dest)
//   busy_out           per-entry busy flags
//   free_count         number of free entries
module rs_bank #(
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned OP_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [OP_W-1:0]              issue_op,
  input  logic [WORD_W-1:0]            issue_vj,
  input  logic [WORD_W-1:0]            issue_vk,
  input  logic [TAG_W-1:0]             issue_qj,
  input  logic [TAG_W-1:0]             issue_qk,
  input  logic                         issue_rdy_j,
  input  logic                         issue_rdy_k,
  input  logic [TAG_W-1:0]             issue_dest,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [WORD_W-1:0]            cdb_value,
  output logic                         ex_valid,
  input  logic                         ex_ready,
  output logic [OP_W-1:0]              ex_op,
  output logic [WORD_W-1:0]            ex_a,
  output logic [WORD_W-1:0]            ex_b,
  output logic [TAG_W-1:0]             ex_dest,
  output logic [NUM_RS-1:0]            busy_out,
  output logic [$clog2(NUM_RS+1)-1:0]  free_count
);

  localparam int unsigned IdxW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int unsigned CntW = $clog2(NUM_RS + 1);

  logic [NUM_RS-1:0] busy_q, busy_d;
  logic [NUM_RS-1:0] rdy_j_q, rdy_j_d;
  logic [NUM_RS-1:0] rdy_k_q, rdy_k_d;
  logic [WORD_W-1:0] vj_q [NUM_RS];
  logic [WORD_W-1:0] vj_d [NUM_RS];
  logic [WORD_W-1:0] vk_q [NUM_RS];
  logic [WORD_W-1:0] vk_d [NUM_RS];
  logic [TAG_W-1:0]  qj_q [NUM_RS];
  logic [TAG_W-1:0]  qj_d [NUM_RS];
  logic [TAG_W-1:0]  qk_q [NUM_RS];
  logic [TAG_W-1:0]  qk_d [NUM_RS];
  logic [TAG_W-1:0]  dest_q [NUM_RS];
  logic [TAG_W-1:0]  dest_d [NUM_RS];
  logic [OP_W-1:0]   op_q [NUM_RS];
  logic [OP_W-1:0]   op_d [NUM_RS];
  // older_q[i][j] set means entry i was allocated before entry j.
  // Only meaningful while both entries are busy.
  logic [NUM_RS-1:0] older_q [NUM_RS];
  logic [NUM_RS-1:0] older_d [NUM_RS];

  logic [NUM_RS-1:0] ready_vec;
  logic [NUM_RS-1:0] oldest_vec;
  logic [IdxW-1:0]   alloc_idx;
  logic [IdxW-1:0]   cand_idx;
  logic              alloc;
  logic              fire;

  // Built from registered rdy bits only, so a CDB capture is never dispatched
  // in the cycle it happens.
  assign ready_vec   = busy_q & rdy_j_q & rdy_k_q;
  assign issue_ready = ~&busy_q;
  assign busy_out    = busy_q;
  assign ex_valid    = |ready_vec;
  assign ex_op       = op_q[cand_idx];
  assign ex_a        = vj_q[cand_idx];
  assign ex_b        = vk_q[cand_idx];
  assign ex_dest     = dest_q[cand_idx];
  assign alloc       = issue_valid && issue_ready && !flush;
  assign fire        = ex_valid && ex_ready && !flush;

  always_comb begin
    alloc_idx  = '0;
    cand_idx   = '0;
    free_count = '0;
    oldest_vec = '0;
    // Descending scan so the lowest free index wins.
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IdxW'(i);
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (!busy_q[i]) free_count = free_count + CntW'(1);
    end
    // An entry is the candidate if it is older than every other ready entry.
    for (int i = 0; i < NUM_RS; i++) begin
      oldest_vec[i] = ready_vec[i];
      for (int j = 0; j < NUM_RS; j++) begin
        if (j != i && ready_vec[j] && !older_q[i][j]) oldest_vec[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (oldest_vec[i]) cand_idx = IdxW'(i);
    end
  end

  always_comb begin
    busy_d  = busy_q;
    rdy_j_d = rdy_j_q;
    rdy_k_d = rdy_k_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    dest_d  = dest_q;
    op_d    = op_q;
    older_d = older_q;

    // CDB snoop for resident entries; tags only matter while rdy is low.
    for (int i = 0; i < NUM_RS; i++) begin
      if (busy_q[i] && cdb_valid) begin
        if (!rdy_j_q[i] && qj_q[i] == cdb_tag) begin
          vj_d[i]    = cdb_value;
          rdy_j_d[i] = 1'b1;
        end
        if (!rdy_k_q[i] && qk_q[i] == cdb_tag) begin
          vk_d[i]    = cdb_value;
          rdy_k_d[i] = 1'b1;
        end
      end
    end

    if (fire) busy_d[cand_idx] = 1'b0;

    // Allocation targets a slot free in the current cycle, so it never collides
    // with the snoop or the dispatch above.
    if (alloc) begin
      busy_d[alloc_idx]  = 1'b1;
      op_d[alloc_idx]    = issue_op;
      dest_d[alloc_idx]  = issue_dest;
      qj_d[alloc_idx]    = issue_qj;
      qk_d[alloc_idx]    = issue_qk;
      vj_d[alloc_idx]    = issue_vj;
      vk_d[alloc_idx]    = issue_vk;
      rdy_j_d[alloc_idx] = issue_rdy_j;
      rdy_k_d[alloc_idx] = issue_rdy_k;
      if (!issue_rdy_j && cdb_valid && cdb_tag == issue_qj) begin
        vj_d[alloc_idx]    = cdb_value;
        rdy_j_d[alloc_idx] = 1'b1;
      end
      if (!issue_rdy_k && cdb_valid && cdb_tag == issue_qk) begin
        vk_d[alloc_idx]    = cdb_value;
        rdy_k_d[alloc_idx] = 1'b1;
      end
      // New entry is younger than everything currently busy.
      older_d[alloc_idx] = '0;
      for (int j = 0; j < NUM_RS; j++) begin
        older_d[j][alloc_idx] = busy_q[j];
      end
    end

    if (flush) begin
      busy_d  = '0;
      rdy_j_d = '0;
      rdy_k_d = '0;
      for (int i = 0; i < NUM_RS; i++) older_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      rdy_j_q <= '0;
      rdy_k_q <= '0;
      for (int i = 0; i < NUM_RS; i++) older_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      rdy_j_q <= rdy_j_d;
      rdy_k_q <= rdy_k_d;
      for (int i = 0; i < NUM_RS; i++) begin
        older_q[i] <= older_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        dest_q[i]  <= dest_d[i];
        op_q[i]    <= op_d[i];
      end
    end
  end

endmodule
